// File: rtl/beam_dac_buffer.sv
// Elastic sample FIFO plus fixed-rate DAC pacer; playback waits for a whole frame or a full buffer.
// Optional build macro BEAM_DAC_BUF_ZERO_IDLE_EN: zero dac_data outside playback and on underflow ticks.
module beam_dac_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int RATE_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        s_t_data,
    input  logic                     s_t_valid,
    output logic                     s_t_ready,
    input  logic                     s_t_last,
    output logic [DATA_W-1:0]        dac_data,
    output logic                     dac_strobe,
    output logic                     playing,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(RATE_DIV);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY} state_t;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q, frames_q;
    logic [DW-1:0]     div_q;
    state_t            state_q;
    logic [DATA_W-1:0] dac_data_q;
    logic              dac_strobe_q, playing_q, underflow_q;

    logic              full, empty, push, tick, pop, push_last, pop_last;
    logic [DATA_W:0]   rd_word;
    logic [PW-1:0]     wr_ptr_d, rd_ptr_d, frames_d, level_d;

    always_comb begin
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        push      = s_t_valid && !full;
        tick      = (state_q == S_PLAY) && (div_q == '0);
        pop       = tick && !empty;
        rd_word   = mem_q[rd_ptr_q[AW-1:0]];
        push_last = push && s_t_last;
        pop_last  = pop && rd_word[DATA_W];
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        frames_d  = frames_q + PW'(push_last) - PW'(pop_last);
        level_d   = wr_ptr_d - rd_ptr_d;
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_t_last, s_t_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frames_q     <= '0;
            div_q        <= '0;
            state_q      <= S_IDLE;
            dac_data_q   <= '0;
            dac_strobe_q <= 1'b0;
            playing_q    <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frames_q     <= frames_d;
            dac_strobe_q <= pop;

            if (pop) begin
                dac_data_q <= rd_word[DATA_W-1:0];
            end
`ifdef BEAM_DAC_BUF_ZERO_IDLE_EN
            else if (tick || state_q != S_PLAY) begin
                dac_data_q <= '0;
            end
`endif

            // A fresh underflow outranks a clear request in the same cycle.
            if (tick && empty) begin
                underflow_q <= 1'b1;
            end else if (clr_flags) begin
                underflow_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (push) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (frames_q != '0 || full) begin
                        state_q   <= S_PLAY;
                        playing_q <= 1'b1;
                        div_q     <= '0;
                    end
                end
                S_PLAY: begin
                    div_q <= (div_q == DW'(RATE_DIV - 1)) ? '0 : div_q + DW'(1);
                    if (pop_last && frames_d == '0) begin
                        playing_q <= 1'b0;
                        state_q   <= (level_d != '0) ? S_FILL : S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_t_ready  = !full;
    assign dac_data   = dac_data_q;
    assign dac_strobe = dac_strobe_q;
    assign playing    = playing_q;
    assign underflow  = underflow_q;
    assign level      = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_beam_dac_buffer.sv
// Directed bench for beam_dac_buffer at default parameters (DATA_W=32, DEPTH=64, RATE_DIV=4).
module tb_beam_dac_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] s_t_data;
    logic        s_t_valid;
    logic        s_t_ready;
    logic        s_t_last;
    logic [31:0] dac_data;
    logic        dac_strobe;
    logic        playing;
    logic        underflow;
    logic [6:0]  level;
    logic        clr_flags;

    beam_dac_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .s_t_data   (s_t_data),
        .s_t_valid  (s_t_valid),
        .s_t_ready  (s_t_ready),
        .s_t_last   (s_t_last),
        .dac_data   (dac_data),
        .dac_strobe (dac_strobe),
        .playing    (playing),
        .underflow  (underflow),
        .level      (level),
        .clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] sd[$];
    int          sc[$];
    logic        sp[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge and every strobe is logged.
    task automatic tick_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (dac_strobe) begin
            sd.push_back(dac_data);
            sc.push_back(cyc);
            sp.push_back(playing);
            $display("sample %0d data=%0h cycle=%0d playing=%0b", sd.size() - 1, dac_data, cyc, playing);
        end
    endtask

    task automatic clear_log();
        sd.delete();
        sc.delete();
        sp.delete();
    endtask

    initial begin
        int k;
        int idx;
        int phase;
        int np;
        int bad;
        logic saw_full;
        logic acc;

        rst = 1'b0; s_t_data = '0; s_t_valid = 1'b0; s_t_last = 1'b0; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick_cycle();
        check_eq("rst_dac_data", dac_data, 0);
        check_eq("rst_strobe", dac_strobe, 0);
        check_eq("rst_playing", playing, 0);
        check_eq("rst_underflow", underflow, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_ready", s_t_ready, 1);

        // 16-word frame, t_last on word 15
        clear_log();
        for (int i = 0; i < 16; i++) begin
            s_t_data = i; s_t_valid = 1'b1; s_t_last = (i == 15);
            tick_cycle();
        end
        k = cyc;
        s_t_valid = 1'b0; s_t_last = 1'b0;
        check_eq("t1_level16", level, 16);
        check_eq("t1_fill_not_playing", playing, 0);
        tick_cycle();
        check_eq("t1_play_at_k1", playing, 1);
        repeat (70) tick_cycle();
        check_eq("t1_count", sd.size(), 16);
        for (int i = 0; i < 16 && i < sd.size(); i++) begin
            check_eq($sformatf("t1_data%0d", i), sd[i], i);
            check_eq($sformatf("t1_cycle%0d", i), sc[i], k + 2 + 4 * i);
        end
        check_eq("t1_idle", playing, 0);
        check_eq("t1_underflow", underflow, 0);
        check_eq("t1_level0", level, 0);

        // Two back-to-back 8-word frames
        clear_log();
        k = 0;
        for (int i = 0; i < 16; i++) begin
            s_t_data = 20 + i; s_t_valid = 1'b1; s_t_last = (i == 7 || i == 15);
            tick_cycle();
            if (i == 7) k = cyc;
        end
        s_t_valid = 1'b0; s_t_last = 1'b0;
        repeat (80) tick_cycle();
        check_eq("t3_count", sd.size(), 16);
        for (int i = 0; i < 16 && i < sd.size(); i++) begin
            check_eq($sformatf("t3_data%0d", i), sd[i], 20 + i);
            check_eq($sformatf("t3_cycle%0d", i), sc[i], k + 2 + 4 * i);
            if (i < 15) check_eq($sformatf("t3_playing%0d", i), sp[i], 1);
        end
        check_eq("t3_idle", playing, 0);
        check_eq("t3_underflow", underflow, 0);

        // Reset after three strobes, then a fresh 4-word frame
        clear_log();
        for (int i = 0; i < 8; i++) begin
            s_t_data = 200 + i; s_t_valid = 1'b1; s_t_last = (i == 7);
            tick_cycle();
        end
        s_t_valid = 1'b0; s_t_last = 1'b0;
        for (int n = 0; n < 100 && sd.size() < 3; n++) tick_cycle();
        check_eq("t5_three_strobes", sd.size(), 3);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_dac_data", dac_data, 0);
        check_eq("t5_rst_strobe", dac_strobe, 0);
        check_eq("t5_rst_playing", playing, 0);
        check_eq("t5_rst_level", level, 0);
        check_eq("t5_rst_ready", s_t_ready, 1);
        #1;
        rst = 1'b1;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            s_t_data = 300 + i; s_t_valid = 1'b1; s_t_last = (i == 3);
            tick_cycle();
        end
        k = cyc;
        s_t_valid = 1'b0; s_t_last = 1'b0;
        repeat (30) tick_cycle();
        check_eq("t5_count", sd.size(), 4);
        for (int i = 0; i < 4 && i < sd.size(); i++) begin
            check_eq($sformatf("t5_data%0d", i), sd[i], 300 + i);
        end
        if (sc.size() > 0) check_eq("t5_first_cycle", sc[0], k + 2);
        check_eq("t5_idle", playing, 0);

        // 80 words with no t_last: fill to 64, play on full, drain into underflow
        clear_log();
        idx = 0;
        saw_full = 1'b0;
        for (int n = 0; n < 2000 && idx < 80; n++) begin
            s_t_data = 100 + idx; s_t_valid = 1'b1; s_t_last = 1'b0;
            if (level == 64 && !saw_full) begin
                saw_full = 1'b1;
                check_eq("t2_ready_low_at_full", s_t_ready, 0);
            end
            acc = s_t_ready;
            tick_cycle();
            if (acc) idx++;
        end
        s_t_valid = 1'b0;
        check_eq("t2_reached_full", saw_full, 1);
        check_eq("t2_all_accepted", idx, 80);
        repeat (340) tick_cycle();
        check_eq("t2_count", sd.size(), 80);
        for (int i = 0; i < 80 && i < sd.size(); i++) begin
            check_eq($sformatf("t2_data%0d", i), sd[i], 100 + i);
            if (i > 0) check_eq($sformatf("t2_gap%0d", i), sc[i] - sc[i-1], 4);
        end
        check_eq("t2_underflow", underflow, 1);
        check_eq("t2_still_playing", playing, 1);
        check_eq("t2_level0", level, 0);
`ifdef BEAM_DAC_BUF_ZERO_IDLE_EN
        check_eq("t2_dac_hold", dac_data, 0);
`else
        check_eq("t2_dac_hold", dac_data, 179);
`endif

        // Clear on an underflow tick: set wins
        phase = (sc.size() > 0) ? sc[sc.size() - 1] % 4 : 0;
        clear_log();
        for (int n = 0; n < 4 && ((cyc + 1) % 4) != phase; n++) tick_cycle();
        clr_flags = 1'b1;
        tick_cycle();
        clr_flags = 1'b0;
        check_eq("t4_set_wins", underflow, 1);
        check_eq("t4_no_strobe", dac_strobe, 0);

        // Clear off-tick while pushing one word, then push only on pop ticks
        clr_flags = 1'b1; s_t_valid = 1'b1; s_t_data = 500;
        tick_cycle();
        clr_flags = 1'b0; s_t_valid = 1'b0;
        check_eq("t4_cleared", underflow, 0);
        check_eq("t6_level1", level, 1);
        np = 0;
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            if (((cyc + 1) % 4) == phase) begin
                s_t_valid = 1'b1; s_t_data = 501 + np; np++;
            end else begin
                s_t_valid = 1'b0;
            end
            tick_cycle();
            if (level != 1) bad++;
        end
        s_t_valid = 1'b0;
        check_eq("t6_level_stable", bad, 0);
        check_eq("t6_count", sd.size(), np);
        for (int i = 0; i < np && i < sd.size(); i++) begin
            check_eq($sformatf("t6_data%0d", i), sd[i], 500 + i);
        end
        check_eq("t6_no_underflow", underflow, 0);

        // Closing word with t_last returns the buffer to IDLE
        s_t_valid = 1'b1; s_t_last = 1'b1; s_t_data = 600;
        tick_cycle();
        s_t_valid = 1'b0; s_t_last = 1'b0;
        repeat (12) tick_cycle();
        check_eq("t6_final_count", sd.size(), np + 2);
        if (sd.size() == np + 2) begin
            check_eq("t6_tail_data", sd[np], 500 + np);
            check_eq("t6_last_data", sd[np + 1], 600);
        end
        check_eq("t6_idle", playing, 0);
        check_eq("t6_level0", level, 0);
        check_eq("t6_underflow", underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
